pipeline_stage_regs: RTL and testbench
======================================

Name: pipeline_stage_regs

Overview:
- Holds the front-end pipeline state of the five-stage RV32I core: the PC register, the IF/ID register and the ID/EX register.
- Acts on the StallF/StallD/FlushD/FlushE controls issued by the hazard logic: holds on stall, inserts a bubble on flush, advances otherwise.
- Tracks a valid bit per stage so downstream logic and the testbench can tell bubbles from real instructions.

Parameters:
- XLEN, 32, datapath width for PC, instruction, operands and immediate.
- CTRL_W, 12, width of the packed decode control bundle; all-zero encodes a no-op (no RegWrite, no MemWrite, no branch, no jump).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on flush or reset (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- StallF  in  1  hold PC register
- StallD  in  1  hold IF/ID register
- FlushD  in  1  bubble IF/ID
- FlushE  in  1  bubble ID/EX
- PCNextF  in  XLEN  next PC, selected upstream (PC+4 or branch target)
- InstrF  in  XLEN  fetched instruction
- PCPlus4F  in  XLEN  PCF+4
- RD1D, RD2D  in  XLEN  register-file read data
- ImmExtD  in  XLEN  extended immediate
- Rs1D, Rs2D, RdD  in  5  register specifiers
- CtrlD  in  CTRL_W  decode control bundle
- PCF  out  XLEN  current fetch PC
- InstrD, PCD, PCPlus4D  out  XLEN  IF/ID contents
- ValidD  out  1  IF/ID holds a real instruction
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN  ID/EX data
- Rs1E, Rs2E, RdE  out  5  ID/EX specifiers
- CtrlE  out  CTRL_W  ID/EX control bundle
- ValidE  out  1  ID/EX holds a real instruction
- StallCnt, FlushCnt  out  32  performance counters (see Optional Feature)

Behaviour:
- Reset, asynchronous, all registers:
  - PCF=RESET_PC.
  - InstrD=NOP_INSTR.
  - PCD, PCPlus4D, all E data/specifiers, CtrlE=0.
  - ValidD=ValidE=0.
  - Counters=0.
- First rising edge after rst deasserts: PCF<=PCNextF, unless StallF.
- PC register: if StallF, hold; else PCF<=PCNextF.
- IF/ID register, priority FlushD > StallD > load:
  - FlushD: InstrD<=NOP_INSTR, PCD<=0, PCPlus4D<=0, ValidD<=0.
  - StallD: hold all fields, including ValidD.
  - Otherwise: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1.
- ID/EX register: no stall input.
  - FlushE: all E data, specifiers and CtrlE <=0, ValidE<=0.
  - Otherwise: capture all D-side inputs, PCE<=PCD, PCPlus4E<=PCPlus4D, ValidE<=ValidD.
- Load-use stall (StallF=StallD=FlushE=1): PC and IF/ID hold for one cycle; ID/EX receives exactly one bubble.
- Taken branch (FlushD=FlushE=1): both D and E become bubbles. PCF takes the branch target from PCNextF, unless StallF is also set, in which case PCF holds.
- StallD=1 with FlushD=1: flush wins.
- Rs*E=0 after a flush makes x0 the specifier, so the forwarding logic never matches.
- Latency: one cycle per stage; no combinational path from inputs to outputs.
- Reset mid-stall or mid-flush: reset dominates immediately; pending holds are discarded.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - StallCnt increments on each clock edge with StallD=1.
  - FlushCnt increments on each edge with FlushE=1 or FlushD=1, counted once per cycle.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package pipe_pkg holds XLEN, CTRL_W, RESET_PC, NOP_INSTR, and the CtrlD bit-field index constants (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ALUControl) shared with the decoder and hazard logic.
- One natural sub-module: pipe_reg, a generic enable/clear register with WIDTH and RESET_VAL parameters and priority clear > hold > load. It is instantiated per field group (PC, IF/ID, ID/EX).

Test Plan:
1. Reset: rst=1 then release, PCNextF=32'h4 -> during reset PCF=0, InstrD=32'h13, ValidD=ValidE=0, CtrlE=0; first edge after release gives PCF=32'h4.
2. Streaming: InstrF=32'h00500093, PCF=32'h8, no controls -> after 1 clk InstrD=32'h00500093, PCD=32'h8, ValidD=1; after 2 clk PCE=32'h8, ValidE=1.
3. Load-use: StallF=StallD=FlushE=1 for one cycle with InstrD=32'h00208133 -> PCF and InstrD unchanged; CtrlE=0, RdE=0, ValidE=0; next cycle the held instruction enters E with ValidE=1.
4. Taken branch: FlushD=FlushE=1, PCNextF=32'h40 -> InstrD=32'h13, ValidD=0, ValidE=0, PCF=32'h40.
5. Conflict: StallD=1 and FlushD=1 together -> flush wins, InstrD=32'h13; asynchronous rst mid-stall clears everything immediately, without waiting for a clock edge.
6. With PIPE_PERF_CNT_EN: 3 stall cycles and 2 flush cycles -> StallCnt=3, FlushCnt=2. Without the macro -> both read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I front-end pipeline: datapath widths,
// reset/bubble constants and the field layout of the packed decode control
// bundle used by the decoder, the hazard unit and the stage registers.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // Bit positions inside CtrlD / CtrlE; bits 11:10 are spare.
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_RESULT_LO  = 1;
  localparam int CTRL_RESULT_HI  = 2;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_JUMP       = 4;
  localparam int CTRL_BRANCH     = 5;
  localparam int CTRL_ALU_SRC    = 6;
  localparam int CTRL_ALU_CTL_LO = 7;
  localparam int CTRL_ALU_CTL_HI = 9;

  // A bundle is a no-op when it cannot change architectural state or flow.
  function automatic logic ctrlIsNop(input logic [CTRL_W-1:0] ctrl);
    return !(ctrl[CTRL_REG_WRITE] | ctrl[CTRL_MEM_WRITE] |
             ctrl[CTRL_JUMP] | ctrl[CTRL_BRANCH]);
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with priority clear > hold > load.
// Clearing loads RESET_VAL, so a flushed stage looks exactly like a stage
// that has just come out of reset (bubble contents and valid bit low).
module pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             hold,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register update: reset dominates, then clear, then hold, else load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (clear) begin
      q <= RESET_VAL;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_stage_regs.sv
// Front-end pipeline state of the five-stage RV32I core: PC register,
// IF/ID register and ID/EX register, driven by the hazard unit's
// StallF/StallD/FlushD/FlushE controls, with a valid bit per stage.
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall/flush
// counters; without it StallCnt/FlushCnt are constant zero.
module pipeline_stage_regs
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [XLEN-1:0]   PCNextF,
  input  logic [XLEN-1:0]   InstrF,
  input  logic [XLEN-1:0]   PCPlus4F,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  input  logic [CTRL_W-1:0] CtrlD,
  output logic [XLEN-1:0]   PCF,
  output logic [XLEN-1:0]   InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              ValidD,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              ValidE,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
);

  localparam int IFID_W = 3 * XLEN + 1;
  localparam int IDEX_W = 5 * XLEN + 15 + CTRL_W + 1;

  // A flushed IF/ID holds the canonical NOP with zero PCs and ValidD low.
  localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INSTR, {(2 * XLEN + 1){1'b0}}};

  logic [IFID_W-1:0] ifidD;
  logic [IFID_W-1:0] ifidQ;
  logic [IDEX_W-1:0] idexD;
  logic [IDEX_W-1:0] idexQ;

  // PC register: never cleared, only held by StallF.
  pipe_reg #(
    .WIDTH     (XLEN),
    .RESET_VAL (RESET_PC)
  ) pcReg (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .hold  (StallF),
    .d     (PCNextF),
    .q     (PCF)
  );

  assign ifidD = {InstrF, PCF, PCPlus4F, 1'b1};

  // IF/ID register: FlushD beats StallD, so a stalled slot can still be squashed.
  pipe_reg #(
    .WIDTH     (IFID_W),
    .RESET_VAL (IFID_BUBBLE)
  ) ifidReg (
    .clk   (clk),
    .rst   (rst),
    .clear (FlushD),
    .hold  (StallD),
    .d     (ifidD),
    .q     (ifidQ)
  );

  assign {InstrD, PCD, PCPlus4D, ValidD} = ifidQ;

  // ID/EX has no stall; an all-zero bubble makes x0 the specifier so
  // forwarding never matches and the control bundle is a no-op.
  assign idexD = {RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, CtrlD, ValidD};

  pipe_reg #(
    .WIDTH     (IDEX_W),
    .RESET_VAL ('0)
  ) idexReg (
    .clk   (clk),
    .rst   (rst),
    .clear (FlushE),
    .hold  (1'b0),
    .d     (idexD),
    .q     (idexQ)
  );

  assign {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, CtrlE, ValidE} = idexQ;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stallCntQ;
  logic [31:0] flushCntQ;

  // Saturating counters: stall cycles seen by decode, and cycles with any flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (StallD && (stallCntQ != 32'hFFFF_FFFF)) begin
        stallCntQ <= stallCntQ + 32'd1;
      end
      if ((FlushD || FlushE) && (flushCntQ != 32'hFFFF_FFFF)) begin
        flushCntQ <= flushCntQ + 32'd1;
      end
    end
  end

  assign StallCnt = stallCntQ;
  assign FlushCnt = flushCntQ;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Testbench for pipeline_stage_regs: directed hazard scenarios plus random
// control/data traffic. A behavioural model predicts each stage's contents;
// predictions go into a scoreboard queue that a separate monitor drains.
module tb_pipeline_stage_regs;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic stallF, stallD, flushD, flushE;
  logic [31:0] pcNextF, instrF, pcPlus4F, rd1D, rd2D, immExtD;
  logic [4:0]  rs1D, rs2D, rdD;
  logic [CTRL_W-1:0] ctrlD;

  logic [31:0] pcF, instrD, pcD, pcPlus4D;
  logic        validD;
  logic [31:0] rd1E, rd2E, immExtE, pcE, pcPlus4E;
  logic [4:0]  rs1E, rs2E, rdE;
  logic [CTRL_W-1:0] ctrlE;
  logic        validE;
  logic [31:0] stallCnt, flushCnt;

  typedef struct {
    logic [31:0] pcF;
    logic [31:0] instrD, pcD, pcPlus4D;
    logic        validD;
    logic [31:0] rd1E, rd2E, immE, pcE, pcPlus4E;
    logic [4:0]  rs1E, rs2E, rdE;
    logic [CTRL_W-1:0] ctrlE;
    logic        validE;
    logic [31:0] stallCnt, flushCnt;
  } pipeState_t;

  pipeState_t model;
  pipeState_t sbQ[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_stage_regs dut (
    .clk      (clk),
    .rst      (rst),
    .StallF   (stallF),
    .StallD   (stallD),
    .FlushD   (flushD),
    .FlushE   (flushE),
    .PCNextF  (pcNextF),
    .InstrF   (instrF),
    .PCPlus4F (pcPlus4F),
    .RD1D     (rd1D),
    .RD2D     (rd2D),
    .ImmExtD  (immExtD),
    .Rs1D     (rs1D),
    .Rs2D     (rs2D),
    .RdD      (rdD),
    .CtrlD    (ctrlD),
    .PCF      (pcF),
    .InstrD   (instrD),
    .PCD      (pcD),
    .PCPlus4D (pcPlus4D),
    .ValidD   (validD),
    .RD1E     (rd1E),
    .RD2E     (rd2E),
    .ImmExtE  (immExtE),
    .PCE      (pcE),
    .PCPlus4E (pcPlus4E),
    .Rs1E     (rs1E),
    .Rs2E     (rs2E),
    .RdE      (rdE),
    .CtrlE    (ctrlE),
    .ValidE   (validE),
    .StallCnt (stallCnt),
    .FlushCnt (flushCnt)
  );

  function automatic pipeState_t resetState();
    pipeState_t s;
    s.pcF = RESET_PC;   s.instrD = NOP_INSTR; s.pcD = '0; s.pcPlus4D = '0;
    s.validD = 1'b0;    s.rd1E = '0; s.rd2E = '0; s.immE = '0; s.pcE = '0;
    s.pcPlus4E = '0;    s.rs1E = '0; s.rs2E = '0; s.rdE = '0; s.ctrlE = '0;
    s.validE = 1'b0;    s.stallCnt = '0; s.flushCnt = '0;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the predicted state.
  task automatic applyStimulus(input logic sF, input logic sD, input logic fD,
                               input logic fE, input logic [31:0] pcNext,
                               input logic [31:0] instr);
    pipeState_t nxt;
    @(negedge clk);
    stallF = sF; stallD = sD; flushD = fD; flushE = fE;
    pcNextF = pcNext; instrF = instr; pcPlus4F = model.pcF + 32'd4;
    rd1D = $urandom; rd2D = $urandom; immExtD = $urandom;
    rs1D = 5'($urandom); rs2D = 5'($urandom); rdD = 5'($urandom);
    ctrlD = CTRL_W'($urandom);

    nxt = model;
    if (!sF) nxt.pcF = pcNext;
    if (fD) begin
      nxt.instrD = NOP_INSTR; nxt.pcD = '0; nxt.pcPlus4D = '0; nxt.validD = 1'b0;
    end else if (!sD) begin
      nxt.instrD = instr; nxt.pcD = model.pcF; nxt.pcPlus4D = model.pcF + 32'd4;
      nxt.validD = 1'b1;
    end
    if (fE) begin
      nxt.rd1E = '0; nxt.rd2E = '0; nxt.immE = '0; nxt.pcE = '0; nxt.pcPlus4E = '0;
      nxt.rs1E = '0; nxt.rs2E = '0; nxt.rdE = '0; nxt.ctrlE = '0; nxt.validE = 1'b0;
    end else begin
      nxt.rd1E = rd1D; nxt.rd2E = rd2D; nxt.immE = immExtD;
      nxt.pcE = model.pcD; nxt.pcPlus4E = model.pcPlus4D;
      nxt.rs1E = rs1D; nxt.rs2E = rs2D; nxt.rdE = rdD; nxt.ctrlE = ctrlD;
      nxt.validE = model.validD;
    end
`ifdef PIPE_PERF_CNT_EN
    if (sD && model.stallCnt != 32'hFFFF_FFFF) nxt.stallCnt = model.stallCnt + 1;
    if ((fD || fE) && model.flushCnt != 32'hFFFF_FFFF) nxt.flushCnt = model.flushCnt + 1;
`endif
    model = nxt;
    sbQ.push_back(nxt);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Assert reset asynchronously, check it took effect with no clock edge, release after an edge.
  task automatic doReset(input string tag);
    rst = 1'b1;
    sbQ.delete();
    model = resetState();
    #1;
    checkOutput({tag, " PCF"}, pcF, 32'h0);
    checkOutput({tag, " InstrD"}, instrD, 32'h13);
    checkOutput({tag, " ValidD"}, 32'(validD), 32'h0);
    checkOutput({tag, " ValidE"}, 32'(validE), 32'h0);
    checkOutput({tag, " CtrlE"}, 32'(ctrlE), 32'h0);
    checkOutput({tag, " RdE"}, 32'(rdE), 32'h0);
    checkOutput({tag, " StallCnt"}, stallCnt, 32'h0);
    checkOutput({tag, " FlushCnt"}, flushCnt, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: after every rising edge, compare the DUT against the oldest prediction.
  initial begin
    pipeState_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("PCF", pcF, e.pcF);
        checkOutput("InstrD", instrD, e.instrD);
        checkOutput("PCD", pcD, e.pcD);
        checkOutput("PCPlus4D", pcPlus4D, e.pcPlus4D);
        checkOutput("ValidD", 32'(validD), 32'(e.validD));
        checkOutput("RD1E", rd1E, e.rd1E);
        checkOutput("RD2E", rd2E, e.rd2E);
        checkOutput("ImmExtE", immExtE, e.immE);
        checkOutput("PCE", pcE, e.pcE);
        checkOutput("PCPlus4E", pcPlus4E, e.pcPlus4E);
        checkOutput("Rs1E", 32'(rs1E), 32'(e.rs1E));
        checkOutput("Rs2E", 32'(rs2E), 32'(e.rs2E));
        checkOutput("RdE", 32'(rdE), 32'(e.rdE));
        checkOutput("CtrlE", 32'(ctrlE), 32'(e.ctrlE));
        checkOutput("ValidE", 32'(validE), 32'(e.validE));
        checkOutput("StallCnt", stallCnt, e.stallCnt);
        checkOutput("FlushCnt", flushCnt, e.flushCnt);
      end
    end
  end

  // Directed hazard scenarios followed by random traffic.
  initial begin
    int r;
    int guard;
    logic [3:0] bits;
    stallF = 0; stallD = 0; flushD = 0; flushE = 0;
    pcNextF = 32'h4; instrF = '0; pcPlus4F = '0; rd1D = '0; rd2D = '0;
    immExtD = '0; rs1D = '0; rs2D = '0; rdD = '0; ctrlD = '0;
    rst = 1'b0;
    #1;
    doReset("reset");

    applyStimulus(0, 0, 0, 0, 32'h4, $urandom);
    settle();
    checkOutput("first edge PCF", pcF, 32'h4);

    applyStimulus(0, 0, 0, 0, 32'h8, $urandom);
    applyStimulus(0, 0, 0, 0, 32'hC, 32'h00500093);
    settle();
    checkOutput("stream InstrD", instrD, 32'h00500093);
    checkOutput("stream PCD", pcD, 32'h8);
    checkOutput("stream ValidD", 32'(validD), 32'h1);
    applyStimulus(0, 0, 0, 0, 32'h10, 32'h00208133);
    settle();
    checkOutput("stream PCE", pcE, 32'h8);
    checkOutput("stream ValidE", 32'(validE), 32'h1);

    applyStimulus(1, 1, 0, 1, 32'h99, $urandom);
    settle();
    checkOutput("load-use PCF", pcF, 32'h10);
    checkOutput("load-use InstrD", instrD, 32'h00208133);
    checkOutput("load-use CtrlE", 32'(ctrlE), 32'h0);
    checkOutput("load-use RdE", 32'(rdE), 32'h0);
    checkOutput("load-use ValidE", 32'(validE), 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h14, $urandom);
    settle();
    checkOutput("load-use release PCE", pcE, 32'hC);
    checkOutput("load-use release ValidE", 32'(validE), 32'h1);

    applyStimulus(0, 0, 1, 1, 32'h40, $urandom);
    settle();
    checkOutput("branch InstrD", instrD, 32'h13);
    checkOutput("branch ValidD", 32'(validD), 32'h0);
    checkOutput("branch ValidE", 32'(validE), 32'h0);
    checkOutput("branch PCF", pcF, 32'h40);

    applyStimulus(0, 1, 1, 0, 32'h44, $urandom);
    settle();
    checkOutput("stall+flush InstrD", instrD, 32'h13);
    checkOutput("stall+flush ValidD", 32'(validD), 32'h0);

    applyStimulus(1, 1, 0, 0, 32'h48, $urandom);
    @(posedge clk);
    #3;
    doReset("mid-stall reset");

    repeat (3) applyStimulus(0, 1, 0, 0, $urandom & 32'hFFFF_FFFC, $urandom);
    repeat (2) applyStimulus(0, 0, 0, 1, $urandom & 32'hFFFF_FFFC, $urandom);
    settle();
`ifdef PIPE_PERF_CNT_EN
    checkOutput("perf StallCnt", stallCnt, 32'd3);
    checkOutput("perf FlushCnt", flushCnt, 32'd2);
`else
    checkOutput("perf StallCnt", stallCnt, 32'd0);
    checkOutput("perf FlushCnt", flushCnt, 32'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      bits = 4'($urandom);
      case (r)
        0, 1:    applyStimulus(1, 1, 0, 1, $urandom & 32'hFFFF_FFFC, $urandom);
        2:       applyStimulus(0, 0, 1, 1, $urandom & 32'hFFFF_FFFC, $urandom);
        3:       applyStimulus(bits[0], bits[1], bits[2], bits[3],
                               $urandom & 32'hFFFF_FFFC, $urandom);
        default: applyStimulus(0, 0, 0, 0, $urandom & 32'hFFFF_FFFC, $urandom);
      endcase
    end

    guard = 0;
    while (sbQ.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
